mem_access_unit: RTL and testbench

Parametrised load/store unit for the MEM stage. It replaces the single-cycle RAM strobe with a request/grant/response bus interface, a posted store buffer and a load state machine. It performs alignment checks, byte-lane steering, and load extraction with sign or zero extension. It stalls the pipeline while a load is outstanding or the store buffer is full.

---
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/grant/response memory bus between the MEM-stage load/store unit (master)
// and the memory system (slave). Stores are posted; loads return data on rvalid.
interface mem_access_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      bus_req;
   logic                      bus_we;
   logic [ADDR_WIDTH-1:0]     bus_addr;
   logic [DATA_WIDTH/8-1:0]   bus_wstrb;
   logic [DATA_WIDTH-1:0]     bus_wdata;
   logic [2:0]                bus_size;
   logic                      bus_gnt;
   logic                      bus_rvalid;
   logic [DATA_WIDTH-1:0]     bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, bus_size,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, bus_size,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment checks, byte-lane steering, posted store
// buffer and a load FSM that waits for the buffer to drain before issuing.
//
// state    | meaning
// IDLE     | no load outstanding; store buffer may drain
// DRAIN    | load waiting for older buffered stores to leave
// LREQ     | load request on the bus, waiting for grant
// LWAIT    | load granted, waiting for rvalid
// LDONE    | load data valid for one cycle, pipeline released
// LDISCARD | flushed load still owed a response; drop it
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SB_DEPTH   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_read_flag_i,
   input  logic                      mem_write_flag_i,
   input  logic                      mem_sign_ext_flag_i,
   input  logic [DATA_WIDTH/8-1:0]   mem_sel_i,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic [DATA_WIDTH-1:0]     write_data_i,
   input  logic                      exc_null_i,
   input  logic                      flush,
   output logic                      stall_req,
   output logic                      load_valid_o,
   output logic [DATA_WIDTH-1:0]     load_data_o,
   output logic                      adel_o,
   output logic                      ades_o,
   output logic [ADDR_WIDTH-1:0]     badvaddr_o,
   mem_access_unit_if.master         bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int LW = $clog2(NB);
   localparam int PW = $clog2(SB_DEPTH);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] DRAIN    = 3'd1;
   localparam logic [2:0] LREQ     = 3'd2;
   localparam logic [2:0] LWAIT    = 3'd3;
   localparam logic [2:0] LDONE    = 3'd4;
   localparam logic [2:0] LDISCARD = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] load_data_q, load_data_d;

   logic [ADDR_WIDTH-1:0] sb_addr_q  [SB_DEPTH];
   logic [NB-1:0]         sb_strb_q  [SB_DEPTH];
   logic [DATA_WIDTH-1:0] sb_data_q  [SB_DEPTH];
   logic [2:0]            sb_size_q  [SB_DEPTH];

   logic [3:0]            sz_bytes;
   logic [2:0]            sz_code;
   logic                  sel_legal, misal, acc_err;
   logic                  load_ok, store_ok;
   logic [LW-1:0]         lane;
   logic [ADDR_WIDTH-1:0] line_addr;
   logic                  sb_full, sb_empty, sb_push, sb_pop, drain_ok;
   logic [DATA_WIDTH-1:0] rd_shift, load_ext;
   logic                  sign_bit;

   logic                  req, we;
   logic [ADDR_WIDTH-1:0] baddr;
   logic [NB-1:0]         wstrb;
   logic [DATA_WIDTH-1:0] wdata;
   logic [2:0]            bsize;

   // A legal size mask is a contiguous run of ones from bit 0 with 1/2/4/8 bytes.
   always_comb begin
      sz_bytes  = '0;
      sel_legal = 1'b1;
      for (int i = 0; i < NB; i++) sz_bytes = sz_bytes + 4'(mem_sel_i[i]);
      for (int i = 0; i < NB; i++)
         if (mem_sel_i[i] != (i < int'(sz_bytes))) sel_legal = 1'b0;
      case (sz_bytes)
         4'd1:    sz_code = 3'd0;
         4'd2:    sz_code = 3'd1;
         4'd4:    sz_code = 3'd2;
         4'd8:    sz_code = 3'd3;
         default: begin sz_code = 3'd0; sel_legal = 1'b0; end
      endcase
      misal = (addr_i[3:0] & (sz_bytes - 4'd1)) != 4'd0;
   end

   assign acc_err    = !sel_legal || misal;
   assign adel_o     = exc_null_i && mem_read_flag_i  && acc_err;
   assign ades_o     = exc_null_i && mem_write_flag_i && acc_err;
   assign badvaddr_o = (adel_o || ades_o) ? addr_i : '0;
   assign load_ok    = exc_null_i && mem_read_flag_i  && !acc_err;
   assign store_ok   = exc_null_i && mem_write_flag_i && !acc_err;

   assign lane      = addr_i[LW-1:0];
   assign line_addr = {addr_i[ADDR_WIDTH-1:LW], {LW{1'b0}}};

   assign sb_empty = (wr_ptr_q == rd_ptr_q);
   assign sb_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign drain_ok = ((state_q == IDLE) || (state_q == DRAIN)) && !sb_empty;
   assign sb_pop   = drain_ok && bus.bus_gnt;
   // Full is judged on registered pointers, so a push waits a cycle behind a pop.
   assign sb_push  = store_ok && !sb_full && !flush;
   assign wr_ptr_d = wr_ptr_q + (PW+1)'(sb_push);
   assign rd_ptr_d = rd_ptr_q + (PW+1)'(sb_pop);

   always_ff @(posedge clk) begin
      if (sb_push) begin
         sb_addr_q[wr_ptr_q[PW-1:0]] <= line_addr;
         sb_strb_q[wr_ptr_q[PW-1:0]] <= mem_sel_i << lane;
         sb_data_q[wr_ptr_q[PW-1:0]] <= write_data_i << {lane, 3'b000};
         sb_size_q[wr_ptr_q[PW-1:0]] <= sz_code;
      end
   end

   always_comb begin
      rd_shift = bus.bus_rdata >> {lane, 3'b000};
      sign_bit = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++)
         if (i == 8 * int'(sz_bytes) - 1) sign_bit = rd_shift[i];
      for (int i = 0; i < DATA_WIDTH; i++)
         load_ext[i] = (i < 8 * int'(sz_bytes)) ? rd_shift[i] : (mem_sign_ext_flag_i & sign_bit);
   end

   always_comb begin
      state_d     = state_q;
      load_data_d = load_data_q;
      case (state_q)
         IDLE:
            if (load_ok && !flush) state_d = sb_empty ? LREQ : DRAIN;
         DRAIN:
            if (flush)         state_d = IDLE;
            else if (sb_empty) state_d = LREQ;
         LREQ:
            if (bus.bus_gnt) state_d = flush ? LDISCARD : LWAIT;
            else if (flush)  state_d = IDLE;
         LWAIT:
            if (bus.bus_rvalid) begin
               state_d = flush ? IDLE : LDONE;
               if (!flush) load_data_d = load_ext;
            end else if (flush) begin
               state_d = LDISCARD;
            end
         LDONE:
            state_d = IDLE;
         LDISCARD:
            if (bus.bus_rvalid) state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   always_comb begin
      req   = 1'b0;
      we    = 1'b0;
      baddr = '0;
      wstrb = '0;
      wdata = '0;
      bsize = '0;
      if (state_q == LREQ) begin
         req   = 1'b1;
         baddr = line_addr;
         bsize = sz_code;
      end else if (drain_ok) begin
         req   = 1'b1;
         we    = 1'b1;
         baddr = sb_addr_q[rd_ptr_q[PW-1:0]];
         wstrb = sb_strb_q[rd_ptr_q[PW-1:0]];
         wdata = sb_data_q[rd_ptr_q[PW-1:0]];
         bsize = sb_size_q[rd_ptr_q[PW-1:0]];
      end
   end

   assign bus.bus_req   = req;
   assign bus.bus_we    = we;
   assign bus.bus_addr  = baddr;
   assign bus.bus_wstrb = wstrb;
   assign bus.bus_wdata = wdata;
   assign bus.bus_size  = bsize;

   assign stall_req    = (load_ok && (state_q != LDONE)) || (store_ok && sb_full);
   assign load_valid_o = (state_q == LDONE) && !flush;
   assign load_data_o  = load_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         load_data_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         load_data_q <= load_data_d;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, store-buffer full/drain,
// misalignment errors and flush of an outstanding load.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_flag_i, mem_write_flag_i, mem_sign_ext_flag_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] addr_i, write_data_i;
   logic        exc_null_i, flush;
   logic        stall_req, load_valid_o, adel_o, ades_o;
   logic [31:0] load_data_o, badvaddr_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

   mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SB_DEPTH(4)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .mem_read_flag_i     (mem_read_flag_i),
      .mem_write_flag_i    (mem_write_flag_i),
      .mem_sign_ext_flag_i (mem_sign_ext_flag_i),
      .mem_sel_i           (mem_sel_i),
      .addr_i              (addr_i),
      .write_data_i        (write_data_i),
      .exc_null_i          (exc_null_i),
      .flush               (flush),
      .stall_req           (stall_req),
      .load_valid_o        (load_valid_o),
      .load_data_o         (load_data_o),
      .adel_o              (adel_o),
      .ades_o              (ades_o),
      .badvaddr_o          (badvaddr_o),
      .bus                 (bus_if)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input string tag, input logic [31:0] a, input logic [3:0] sel,
                          input logic sx, input logic [31:0] rd, input logic [2:0] sz,
                          input logic [31:0] exp);
      mem_read_flag_i = 1'b1; mem_sign_ext_flag_i = sx; mem_sel_i = sel; addr_i = a;
      #1 chk({tag, "_stall_c0"}, stall_req, 1);
      chk({tag, "_noreq_c0"}, bus_if.bus_req, 0);
      tick();
      bus_if.bus_gnt = 1'b1;
      #1 chk({tag, "_req_c1"}, bus_if.bus_req, 1);
      chk({tag, "_we_c1"}, bus_if.bus_we, 0);
      chk({tag, "_addr_c1"}, bus_if.bus_addr, {a[31:2], 2'b00});
      chk({tag, "_size_c1"}, bus_if.bus_size, sz);
      chk({tag, "_stall_c1"}, stall_req, 1);
      tick();
      bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = rd;
      #1 chk({tag, "_stall_c2"}, stall_req, 1);
      tick();
      bus_if.bus_rvalid = 1'b0;
      #1 chk({tag, "_valid_c3"}, load_valid_o, 1);
      chk({tag, "_data_c3"}, load_data_o, exp);
      chk({tag, "_stall_c3"}, stall_req, 0);
      tick();
      mem_read_flag_i = 1'b0;
      #1 chk({tag, "_valid_c4"}, load_valid_o, 0);
   endtask

   initial begin
      rst = 1'b1;
      mem_read_flag_i = 0; mem_write_flag_i = 0; mem_sign_ext_flag_i = 0;
      mem_sel_i = 0; addr_i = 0; write_data_i = 0; exc_null_i = 1; flush = 0;
      bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
      tick(); tick();
      rst = 1'b0;
      #1 chk("rst_stall", stall_req, 0);
      chk("rst_req", bus_if.bus_req, 0);
      chk("rst_valid", load_valid_o, 0);
      chk("rst_data", load_data_o, 0);
      chk("rst_badv", badvaddr_o, 0);

      do_load("ldw", 32'h100, 4'hF, 1'b0, 32'h80FF_1234, 3'd2, 32'h80FF_1234);
      do_load("ldb_s", 32'h103, 4'h1, 1'b1, 32'h8000_0000, 3'd0, 32'hFFFF_FF80);
      do_load("ldb_u", 32'h103, 4'h1, 1'b0, 32'h8000_0000, 3'd0, 32'h0000_0080);
      do_load("ldh_s", 32'h102, 4'h3, 1'b1, 32'h9ABC_0000, 3'd1, 32'hFFFF_9ABC);

      // halfword store at 0x102
      mem_write_flag_i = 1; mem_sel_i = 4'h3; addr_i = 32'h102; write_data_i = 32'hABCD;
      #1 chk("sth_stall", stall_req, 0);
      tick();
      mem_write_flag_i = 0;
      #1 chk("sth_req", bus_if.bus_req, 1);
      chk("sth_we", bus_if.bus_we, 1);
      chk("sth_addr", bus_if.bus_addr, 32'h100);
      chk("sth_strb", bus_if.bus_wstrb, 4'b1100);
      chk("sth_wdata", bus_if.bus_wdata, 32'hABCD_0000);
      chk("sth_size", bus_if.bus_size, 1);
      bus_if.bus_gnt = 1;
      tick();
      bus_if.bus_gnt = 0;
      #1 chk("sth_drained", bus_if.bus_req, 0);

      // five stores against a stalled bus
      for (int i = 0; i < 5; i++) begin
         mem_write_flag_i = 1; mem_sel_i = 4'hF;
         addr_i = 32'h200 + 32'(4 * i); write_data_i = 32'h1111_0000 + 32'(i);
         if (i < 4) begin
            #1 chk("sbf_nostall", stall_req, 0);
            tick();
         end
      end
      #1 chk("sbf_stall5", stall_req, 1);
      tick();
      #1 chk("sbf_stall5_hold", stall_req, 1);
      chk("sbf_hold_addr", bus_if.bus_addr, 32'h200);
      bus_if.bus_gnt = 1;
      #1 chk("sbf_head_data", bus_if.bus_wdata, 32'h1111_0000);
      tick();
      bus_if.bus_gnt = 0;
      #1 chk("sbf_stall_clear", stall_req, 0);
      tick();
      mem_write_flag_i = 0;
      for (int j = 1; j <= 4; j++) begin
         bus_if.bus_gnt = 1;
         #1 chk("sbf_order_addr", bus_if.bus_addr, 32'h200 + 32'(4 * j));
         chk("sbf_order_data", bus_if.bus_wdata, 32'h1111_0000 + 32'(j));
         tick();
         bus_if.bus_gnt = 0;
      end
      #1 chk("sbf_empty", bus_if.bus_req, 0);

      // store followed by a load while the store grant is delayed
      mem_write_flag_i = 1; mem_sel_i = 4'hF; addr_i = 32'h300; write_data_i = 32'hDEAD_BEEF;
      tick();
      mem_write_flag_i = 0; mem_read_flag_i = 1; addr_i = 32'h100; mem_sign_ext_flag_i = 0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("dr_stall", stall_req, 1);
         chk("dr_store_we", bus_if.bus_we, 1);
         chk("dr_store_addr", bus_if.bus_addr, 32'h300);
         tick();
      end
      bus_if.bus_gnt = 1;
      tick();
      bus_if.bus_gnt = 0;
      #1 chk("dr_gap_req", bus_if.bus_req, 0);
      chk("dr_gap_stall", stall_req, 1);
      tick();
      #1 chk("dr_lreq_req", bus_if.bus_req, 1);
      chk("dr_lreq_we", bus_if.bus_we, 0);
      chk("dr_lreq_strb", bus_if.bus_wstrb, 0);
      chk("dr_lreq_addr", bus_if.bus_addr, 32'h100);
      bus_if.bus_gnt = 1;
      tick();
      bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h1234_5678;
      tick();
      bus_if.bus_rvalid = 0;
      #1 chk("dr_valid", load_valid_o, 1);
      chk("dr_data", load_data_o, 32'h1234_5678);
      tick();
      mem_read_flag_i = 0;

      // address errors
      mem_read_flag_i = 1; mem_sel_i = 4'hF; addr_i = 32'h102;
      #1 chk("mis_adel", adel_o, 1);
      chk("mis_ades", ades_o, 0);
      chk("mis_badv", badvaddr_o, 32'h102);
      chk("mis_stall", stall_req, 0);
      tick();
      #1 chk("mis_noreq", bus_if.bus_req, 0);
      mem_sel_i = 4'b0101; addr_i = 32'h100;
      #1 chk("ill_sel_adel", adel_o, 1);
      mem_read_flag_i = 0; mem_write_flag_i = 1; mem_sel_i = 4'h3; addr_i = 32'h101;
      #1 chk("mis_ades_st", ades_o, 1);
      chk("mis_ades_badv", badvaddr_o, 32'h101);
      exc_null_i = 0;
      #1 chk("mis_gated", ades_o, 0);
      tick();
      #1 chk("mis_st_noreq", bus_if.bus_req, 0);
      exc_null_i = 1; mem_write_flag_i = 0;

      // flush while waiting for load data
      mem_read_flag_i = 1; mem_sel_i = 4'hF; addr_i = 32'h100;
      tick();
      bus_if.bus_gnt = 1;
      tick();
      bus_if.bus_gnt = 0; flush = 1;
      #1 chk("fl_valid_lwait", load_valid_o, 0);
      tick();
      flush = 0; mem_read_flag_i = 0;
      #1 chk("fl_disc_req", bus_if.bus_req, 0);
      chk("fl_disc_valid", load_valid_o, 0);
      bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'hAAAA_AAAA;
      tick();
      bus_if.bus_rvalid = 0;
      #1 chk("fl_after_valid", load_valid_o, 0);
      chk("fl_after_data", load_data_o, 32'h1234_5678);
      do_load("fl_next", 32'h104, 4'hF, 1'b0, 32'h5566_7788, 3'd2, 32'h5566_7788);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
